// File: rtl/alu_wrapper_if.sv
// Execute-stage ALU bus: operands, function code and flag-load strobe in; valE, overflow and condition codes out.
interface alu_wrapper_if;
    logic [1:0]  alu_fun;
    logic [63:0] alu_b;
    logic [63:0] alu_a;
    logic        flag_we;
    logic [63:0] alu_out;
    logic        alu_of;
    logic        zf;
    logic        sf;
    logic        of;

    modport master (
        output alu_fun, alu_b, alu_a, flag_we,
        input  alu_out, alu_of, zf, sf, of
    );

    modport slave (
        input  alu_fun, alu_b, alu_a, flag_we,
        output alu_out, alu_of, zf, sf, of
    );
endinterface

// File: rtl/alu_wrapper.sv
// Y86-64 execute-stage ALU (add/sub/and/xor) with signed overflow and a ZF/SF/OF condition-code register.
// Optional macro ALU_OUT_REG_EN registers alu_out/alu_of for one cycle of result latency.
module alu_wrapper (
    input  logic          clk,
    input  logic          rst_n,
    alu_wrapper_if.slave  bus
);

    localparam logic [1:0] FUN_ADD = 2'd0;
    localparam logic [1:0] FUN_SUB = 2'd1;
    localparam logic [1:0] FUN_AND = 2'd2;
    localparam logic [1:0] FUN_XOR = 2'd3;

    function automatic logic add_ovf(input logic signed [63:0] a,
                                     input logic signed [63:0] b,
                                     input logic signed [63:0] r);
        return (a[63] == b[63]) && (r[63] != a[63]);
    endfunction

    // B - A: overflow only when operand signs differ and the result leaves B's sign
    function automatic logic sub_ovf(input logic signed [63:0] a,
                                     input logic signed [63:0] b,
                                     input logic signed [63:0] r);
        return (b[63] != a[63]) && (r[63] != b[63]);
    endfunction

    logic signed [63:0] w_a;
    logic signed [63:0] w_b;
    logic signed [63:0] w_sum;
    logic signed [63:0] w_diff;
    logic signed [63:0] w_res;
    logic               w_of;

    assign w_a    = bus.alu_a;
    assign w_b    = bus.alu_b;
    assign w_sum  = w_b + w_a;
    assign w_diff = w_b + ~w_a + 64'sd1;

    always_comb begin
        w_res = '0;
        w_of  = 1'b0;
        case (bus.alu_fun)
            FUN_ADD: begin
                w_res = w_sum;
                w_of  = add_ovf(w_a, w_b, w_sum);
            end
            FUN_SUB: begin
                w_res = w_diff;
                w_of  = sub_ovf(w_a, w_b, w_diff);
            end
            FUN_AND: w_res = w_b & w_a;
            FUN_XOR: w_res = w_b ^ w_a;
            default: ;
        endcase
    end

    logic r_zf;
    logic r_sf;
    logic r_of;

    // Flags always come from the unregistered result, independent of output registering
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zf <= 1'b0;
            r_sf <= 1'b0;
            r_of <= 1'b0;
        end else if (bus.flag_we) begin
            r_zf <= (w_res == 64'sd0);
            r_sf <= w_res[63];
            r_of <= w_of;
        end
    end

    assign bus.zf = r_zf;
    assign bus.sf = r_sf;
    assign bus.of = r_of;

`ifdef ALU_OUT_REG_EN
    logic [63:0] r_alu_out;
    logic        r_alu_of;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_out <= '0;
            r_alu_of  <= 1'b0;
        end else begin
            r_alu_out <= w_res;
            r_alu_of  <= w_of;
        end
    end

    assign bus.alu_out = r_alu_out;
    assign bus.alu_of  = r_alu_of;
`else
    assign bus.alu_out = w_res;
    assign bus.alu_of  = w_of;
`endif

endmodule

// File: tb/tb_alu_wrapper.sv
// Directed-vector bench for alu_wrapper: result/overflow per operation, flag load/hold, async reset.
module tb_alu_wrapper;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    alu_wrapper_if bus ();

    alu_wrapper dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic ezf, input logic esf, input logic eof);
        check_eq({tag, ".zf"}, 64'(bus.zf), 64'(ezf));
        check_eq({tag, ".sf"}, 64'(bus.sf), 64'(esf));
        check_eq({tag, ".of"}, 64'(bus.of), 64'(eof));
    endtask

    // Apply at negedge, check the result before and after the following rising edge
    task automatic vec(input string tag, input logic [1:0] fun, input logic [63:0] b,
                       input logic [63:0] a, input logic we,
                       input logic [63:0] eout, input logic eof);
        @(negedge clk);
        bus.alu_fun = fun;
        bus.alu_b   = b;
        bus.alu_a   = a;
        bus.flag_we = we;
`ifndef ALU_OUT_REG_EN
        #1;
        check_eq({tag, ".out0"}, bus.alu_out, eout);
        check_eq({tag, ".aof0"}, 64'(bus.alu_of), 64'(eof));
`endif
        @(posedge clk);
        #1;
        check_eq({tag, ".out"}, bus.alu_out, eout);
        check_eq({tag, ".aof"}, 64'(bus.alu_of), 64'(eof));
    endtask

    initial begin
        n_cmp       = 0;
        n_mis       = 0;
        rst_n       = 1'b0;
        bus.alu_fun = 2'd0;
        bus.alu_b   = '0;
        bus.alu_a   = '0;
        bus.flag_we = 1'b0;

        #12;
        check_flags("reset", 1'b0, 1'b0, 1'b0);
`ifdef ALU_OUT_REG_EN
        check_eq("reset.out", bus.alu_out, 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        vec("add", 2'd0, 64'd7, 64'd5, 1'b1, 64'd12, 1'b0);
        check_flags("add", 1'b0, 1'b0, 1'b0);
        vec("subz", 2'd1, 64'h1234, 64'h1234, 1'b1, 64'd0, 1'b0);
        check_flags("subz", 1'b1, 1'b0, 1'b0);
        vec("subn", 2'd1, 64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        check_flags("subn", 1'b0, 1'b1, 1'b0);
        vec("addov", 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        check_flags("addov", 1'b0, 1'b1, 1'b1);
        vec("addnov", 2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
            64'd0, 1'b1);
        check_flags("addnov", 1'b1, 1'b0, 1'b1);
        vec("subov", 2'd1, 64'h8000_0000_0000_0000, 64'd1, 1'b1,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        check_flags("subov", 1'b0, 1'b0, 1'b1);
        vec("subpov", 2'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
            64'h8000_0000_0000_0000, 1'b1);
        check_flags("subpov", 1'b0, 1'b1, 1'b1);
        vec("and", 2'd2, 64'hF0F0, 64'hFF00, 1'b1, 64'hF000, 1'b0);
        check_flags("and", 1'b0, 1'b0, 1'b0);
        vec("xor", 2'd3, 64'hF0F0, 64'hFF00, 1'b1, 64'h0FF0, 1'b0);
        vec("xorz", 2'd3, 64'hAAAA, 64'hAAAA, 1'b1, 64'd0, 1'b0);
        check_flags("xorz", 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            vec("hold", 2'd1, 64'd3, 64'd5 + 64'(i), 1'b0, 64'd3 - 64'd5 - 64'(i), 1'b0);
            check_flags("hold", 1'b1, 1'b0, 1'b0);
        end

        vec("stack", 2'd0, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 64'hF8, 1'b0);
        check_flags("stack", 1'b0, 1'b0, 1'b0);

        vec("prerst", 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        check_flags("prerst", 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_flags("asyncrst", 1'b0, 1'b0, 1'b0);
`ifdef ALU_OUT_REG_EN
        check_eq("asyncrst.out", bus.alu_out, 64'd0);
        check_eq("asyncrst.aof", 64'(bus.alu_of), 64'd0);
`endif
        @(posedge clk);
        #1;
        check_flags("inrst", 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        bus.alu_fun = 2'd3;
        bus.alu_b   = 64'h55;
        bus.alu_a   = 64'h55;
        bus.flag_we = 1'b0;
        rst_n       = 1'b1;
        @(posedge clk);
        #1;
        check_flags("postrst", 1'b0, 1'b0, 1'b0);
        vec("firstld", 2'd3, 64'h55, 64'h55, 1'b1, 64'd0, 1'b0);
        check_flags("firstld", 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
